mem_port_arbiter: RTL and testbench

- Shares the CPU's single external memory port between instruction fetch (driven by the PC and fetch-enable) and the MEM stage (loads/stores).
- Sequences each bus transaction with a req/ack handshake and a watchdog.
- Generates the 6-bit pipeline stall vector consumed by the PC register, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Also merges the stall request from EX (multi-cycle ops).

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_ack_watchdog.sv | 30 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the external memory port arbiter: bus widths,
// arbiter states, pipeline stall patterns and legacy control constants.
package mem_port_arbiter_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic ChipEnable = 1'b1;
  localparam logic Stop       = 1'b1;
  localparam logic NoStop     = 1'b0;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned RegBus      = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IF_WAIT,
    ST_MEM_WAIT
  } arb_state_e;

  // Stall vector bits: {wb, mem, ex, id, if, pc}
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/mem_port_arbiter_ack_watchdog.sv
// Bus acknowledge watchdog: counts waiting cycles and flags the cycle in
// which the LIMIT-th cycle elapses without an acknowledge.
module ack_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of waiting cycles already completed
  assign timeout = en && !clr && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and
// the MEM stage, and produces the pipeline stall vector.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = InstAddrBus,
  parameter int unsigned DATA_W      = RegBus,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  input  logic              stallreq_from_ex_i,
  output logic [5:0]        stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              bus_err_o
);

  arb_state_e state, state_next;

  logic waiting;
  logic timeout;
  logic done;
  logic if_done;
  logic mem_done;
  logic abort;
  logic issue_if;
  logic issue_mem;

  ack_watchdog #(
    .LIMIT (ACK_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_IDLE),
    .en      (waiting),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (mem_req_i) begin
          state_next = ST_MEM_WAIT;
        end else if (if_ce_i == ChipEnable) begin
          state_next = ST_IF_WAIT;
        end
      end
      ST_IF_WAIT, ST_MEM_WAIT: begin
        if (bus_ack_i || timeout) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    waiting   = (state != ST_IDLE);
    done      = waiting && (bus_ack_i || timeout);
    if_done   = (state == ST_IF_WAIT) && done;
    mem_done  = (state == ST_MEM_WAIT) && done;
    abort     = waiting && timeout && !bus_ack_i;
    issue_mem = (state == ST_IDLE) && (state_next == ST_MEM_WAIT);
    issue_if  = (state == ST_IDLE) && (state_next == ST_IF_WAIT);

    if_inst_o   = ((state == ST_IF_WAIT) && bus_ack_i) ? bus_rdata_i : '0;
    mem_rdata_o = ((state == ST_MEM_WAIT) && bus_ack_i) ? bus_rdata_i : '0;

    // A completing (or aborted) requester no longer holds the pipeline
    if (rst == RstEnable) begin
      stall_o = STALL_NONE;
    end else if (mem_req_i && !mem_done) begin
      stall_o = STALL_MEM;
    end else if (stallreq_from_ex_i == Stop) begin
      stall_o = STALL_EX;
    end else if ((if_ce_i == ChipEnable) && !if_done) begin
      stall_o = STALL_IF;
    end else begin
      stall_o = STALL_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_sel_o   <= '0;
      bus_err_o   <= 1'b0;
    end else begin
      bus_err_o <= abort;
      if (issue_mem) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= mem_we_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
        bus_sel_o   <= mem_sel_i;
      end else if (issue_if) begin
        bus_req_o  <= 1'b1;
        bus_we_o   <= 1'b0;
        bus_addr_o <= if_addr_i;
        bus_sel_o  <= '1;
      end else if (done) begin
        bus_req_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter acting as bus slave, with a queue of
// expected bus transactions checked as each one is issued.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_rdata_o;
  logic        stallreq_from_ex_i;
  logic [5:0]  stall_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } txn_t;

  txn_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .SEL_W       (4),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .if_ce_i            (if_ce_i),
    .if_addr_i          (if_addr_i),
    .if_inst_o          (if_inst_o),
    .mem_req_i          (mem_req_i),
    .mem_we_i           (mem_we_i),
    .mem_addr_i         (mem_addr_i),
    .mem_wdata_i        (mem_wdata_i),
    .mem_sel_i          (mem_sel_i),
    .mem_rdata_o        (mem_rdata_o),
    .stallreq_from_ex_i (stallreq_from_ex_i),
    .stall_o            (stall_o),
    .bus_req_o          (bus_req_o),
    .bus_we_o           (bus_we_o),
    .bus_addr_o         (bus_addr_o),
    .bus_wdata_o        (bus_wdata_o),
    .bus_sel_o          (bus_sel_o),
    .bus_ack_i          (bus_ack_i),
    .bus_rdata_i        (bus_rdata_i),
    .bus_err_o          (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] addr);
    txn_t t;
    t.we = 1'b0; t.addr = addr; t.wdata = '0; t.sel = 4'hF;
    exp_q.push_back(t);
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.sel = sel;
    exp_q.push_back(t);
  endtask

  task automatic check_issue(input string tag);
    txn_t t;
    chk({tag, "_qdepth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      chk({tag, "_req"}, {31'd0, bus_req_o}, 1);
      chk({tag, "_we"}, {31'd0, bus_we_o}, {31'd0, t.we});
      chk({tag, "_addr"}, bus_addr_o, t.addr);
      chk({tag, "_sel"}, {28'd0, bus_sel_o}, {28'd0, t.sel});
      if (t.we) chk({tag, "_wdata"}, bus_wdata_o, t.wdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_ce_i = 1'b1; if_addr_i = '0;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; mem_sel_i = '0;
    stallreq_from_ex_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;

    // Reset state, even with requests pending
    tick(); tick();
    chk("rst_stall", {26'd0, stall_o}, 32'h00);
    chk("rst_req", {31'd0, bus_req_o}, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_err", {31'd0, bus_err_o}, 0);
    chk("rst_inst", if_inst_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);

    // Fetch at pc 0, ack in the first waiting cycle
    rst = 1'b0; mem_req_i = 1'b0; if_ce_i = 1'b1; if_addr_i = 32'h0;
    settle();
    chk("f0_issue_stall", {26'd0, stall_o}, 32'h07);
    chk("f0_issue_req", {31'd0, bus_req_o}, 0);
    push_fetch(32'h0);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h2401_0001;
    settle();
    check_issue("f0");
    chk("f0_ack_stall", {26'd0, stall_o}, 32'h00);
    chk("f0_inst", if_inst_o, 32'h2401_0001);
    chk("f0_mem_rdata", mem_rdata_o, 0);

    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0; if_addr_i = 32'h4;
    settle();
    chk("f4_idle_req", {31'd0, bus_req_o}, 0);
    chk("f4_idle_stall", {26'd0, stall_o}, 32'h07);
    chk("f4_idle_inst", if_inst_o, 0);
    push_fetch(32'h4);
    tick();
    settle();
    check_issue("f4");
    chk("f4_wait_stall", {26'd0, stall_o}, 32'h07);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h8C02_0100;
    settle();
    chk("f4_inst", if_inst_o, 32'h8C02_0100);

    // Store while idle, ack in the third waiting cycle
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0; if_addr_i = 32'h8;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h100;
    mem_wdata_i = 32'hDEAD_BEEF; mem_sel_i = 4'hF;
    settle();
    chk("st_idle_stall", {26'd0, stall_o}, 32'h1F);
    push_mem(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    tick();
    settle();
    check_issue("st");
    chk("st_w1_stall", {26'd0, stall_o}, 32'h1F);
    tick();
    settle();
    chk("st_w2_we", {31'd0, bus_we_o}, 1);
    chk("st_w2_addr", bus_addr_o, 32'h100);
    chk("st_w2_stall", {26'd0, stall_o}, 32'h1F);
    tick();
    bus_ack_i = 1'b1;
    settle();
    chk("st_w3_we", {31'd0, bus_we_o}, 1);
    chk("st_ack_stall", {26'd0, stall_o}, 32'h07);
    chk("st_ack_err", {31'd0, bus_err_o}, 0);

    // Fetch resumes; a load request arrives while it is in flight
    tick();
    bus_ack_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    settle();
    chk("f8_idle_req", {31'd0, bus_req_o}, 0);
    chk("f8_idle_stall", {26'd0, stall_o}, 32'h07);
    push_fetch(32'h8);
    tick();
    mem_req_i = 1'b1; mem_addr_i = 32'h200; mem_sel_i = 4'h3;
    settle();
    check_issue("f8");
    chk("ld_during_if_stall", {26'd0, stall_o}, 32'h1F);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    settle();
    chk("f8_inst", if_inst_o, 32'h1111_1111);
    chk("f8_ack_addr", bus_addr_o, 32'h8);
    chk("f8_ack_stall", {26'd0, stall_o}, 32'h1F);
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    settle();
    chk("ld_idle_req", {31'd0, bus_req_o}, 0);
    chk("ld_idle_stall", {26'd0, stall_o}, 32'h1F);
    push_mem(1'b0, 32'h200, 32'h0, 4'h3);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
    settle();
    check_issue("ld");
    chk("ld_rdata", mem_rdata_o, 32'hCAFE_F00D);
    chk("ld_inst_zero", if_inst_o, 0);
    chk("ld_ack_stall", {26'd0, stall_o}, 32'h07);

    // EX stall alone, then with a concurrent memory request
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0; mem_req_i = 1'b0; if_ce_i = 1'b0;
    stallreq_from_ex_i = 1'b1;
    settle();
    chk("ex_stall", {26'd0, stall_o}, 32'h0F);
    chk("ex_req", {31'd0, bus_req_o}, 0);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
    settle();
    chk("ex_mem_stall", {26'd0, stall_o}, 32'h1F);
    push_mem(1'b0, 32'h300, 32'h0, 4'hF);

    // No ack: watchdog aborts in the fourth waiting cycle
    tick();
    stallreq_from_ex_i = 1'b0; bus_rdata_i = 32'hFFFF_FFFF;
    settle();
    check_issue("to");
    for (int unsigned i = 1; i < 4; i++) begin
      chk("to_wait_stall", {26'd0, stall_o}, 32'h1F);
      chk("to_wait_err", {31'd0, bus_err_o}, 0);
      tick();
      settle();
    end
    chk("to_abort_stall", {26'd0, stall_o}, 32'h00);
    chk("to_abort_rdata", mem_rdata_o, 0);
    chk("to_abort_req", {31'd0, bus_req_o}, 1);
    tick();
    mem_req_i = 1'b0; bus_rdata_i = '0;
    settle();
    chk("to_err_pulse", {31'd0, bus_err_o}, 1);
    chk("to_req_drop", {31'd0, bus_req_o}, 0);
    tick();
    settle();
    chk("to_err_end", {31'd0, bus_err_o}, 0);

    // Reset during MEM_WAIT, then a late ack
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h400; mem_wdata_i = 32'h1234_5678;
    settle();
    push_mem(1'b1, 32'h400, 32'h1234_5678, 4'hF);
    tick();
    settle();
    check_issue("rm");
    rst = 1'b1;
    settle();
    chk("rm_req_drop", {31'd0, bus_req_o}, 0);
    chk("rm_addr_clr", bus_addr_o, 0);
    chk("rm_stall", {26'd0, stall_o}, 32'h00);
    tick();
    mem_req_i = 1'b0; mem_we_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    settle();
    chk("rm_ack_rdata", mem_rdata_o, 0);
    tick();
    rst = 1'b0; if_ce_i = 1'b1; if_addr_i = 32'h10;
    settle();
    chk("rm_stray_inst", if_inst_o, 0);
    chk("rm_stray_rdata", mem_rdata_o, 0);
    chk("rm_fetch_stall", {26'd0, stall_o}, 32'h07);
    push_fetch(32'h10);
    tick();
    bus_ack_i = 1'b0;
    settle();
    check_issue("rf");
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0013;
    settle();
    chk("rf_inst", if_inst_o, 32'h0000_0013);
    chk("rf_stall", {26'd0, stall_o}, 32'h00);
    tick();
    bus_ack_i = 1'b0; if_ce_i = 1'b0;
    settle();
    chk("end_qdepth", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
